if_id_hazard_reg: RTL
=====================

Name: if_id_hazard_reg

Overview:
- IF/ID pipeline register plus hazard-response controller.
- Acts on the one-cycle load-use stall request from the ID-stage load-stall detector and on taken branch/jump flush requests.
- Holds the PC and IF/ID contents, injects a bubble into ID/EX, and squashes the fetched instruction on flush.
- Bounds consecutive stalls with a watchdog counter so a stuck stall request cannot deadlock the pipeline.

Parameters:
- MAX_STALL, 1, maximum consecutive held cycles before forced release (1..15).
- NOP_INSTR, 32'h00000000, encoding loaded into IF/ID on flush/reset (R-type, rd=r0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_req  in  1  load-use stall request from the load-stall detector (combinational, same cycle).
- flush_req  in  1  taken branch/jump resolved; squash the IF instruction.
- instr_if  in  32  fetched instruction.
- pc_plus4_if  in  32  PC+4 of the fetched instruction.
- instr_id  out  32  registered instruction in ID.
- pc_plus4_id  out  32  registered PC+4 in ID.
- valid_id  out  1  ID instruction is real (0 = bubble).
- pc_write_en  out  1  PC register enable (combinational).
- bubble_ex  out  1  zero ID/EX control signals this cycle (combinational).
- stall_overflow  out  1  sticky; set on watchdog release.
- stall_cycles  out  32  held-cycle count (see Optional Feature).

Behaviour:
- Reset (sync, clk edge with reset=1):
  - instr_id=NOP_INSTR, pc_plus4_id=0, valid_id=0.
  - State=RUN, cnt=0, stall_overflow=0, stall_cycles=0.
  - While reset=1: pc_write_en=0, bubble_ex=1.
- eff_stall = stall_req & valid_id. A bubble in ID never stalls.
- Priority: reset > flush_req > eff_stall > normal advance.
- Normal advance (no flush, no eff_stall):
  - pc_write_en=1, bubble_ex=0.
  - Next edge: instr_id<=instr_if, pc_plus4_id<=pc_plus4_if, valid_id<=1, cnt<=0.
- Flush (flush_req=1, any state):
  - pc_write_en=1 (PC takes target), bubble_ex=0.
  - Next edge: instr_id<=NOP_INSTR, valid_id<=0, pc_plus4_id<=pc_plus4_if, cnt<=0, state<=RUN.
  - A simultaneous stall_req is ignored.
- Stall (eff_stall=1, no flush, cnt<MAX_STALL):
  - pc_write_en=0, bubble_ex=1.
  - IF/ID registers hold; cnt<=cnt+1; state<=STALL.
- Watchdog (eff_stall=1, no flush, cnt==MAX_STALL):
  - Treated as normal advance: pc_write_en=1, bubble_ex=0.
  - Next edge: stall_overflow<=1, cnt<=0, state<=RUN.
- State machine:
  - RUN->STALL on a stall.
  - STALL->STALL while stalled and cnt<MAX_STALL.
  - STALL->RUN on advance, flush or watchdog.
  - The state is informational plus cnt gating; outputs depend on cnt and inputs as above.
- Latency: IF->ID is 1 cycle. A load-use stall with MAX_STALL=1 costs exactly 1 cycle.
- stall_overflow clears only on reset.
- cnt width = 4 bits; MAX_STALL outside 1..15 is an elaboration error.

Optional Feature:
- Macro: IF_ID_STALL_PERF_EN.
- Defined: stall_cycles increments on every clk edge where pc_write_en=0 and reset=0; saturates at 32'hFFFFFFFF; reset clears it.
- Undefined: stall_cycles tied to 0 and no counter logic is built.

Decomposition:
- Shared package pipeline_pkg holds NOP_INSTR, the opcode field constants (RTYPE 6'b000000, store/jump masks) and the state enum {RUN, STALL}.
- One natural sub-module: stall_watchdog (cnt register, compare to MAX_STALL, overflow flag).

Test Plan:
- Reset: hold reset 2 cycles with instr_if=32'h8C410004 -> instr_id=0, valid_id=0, pc_write_en=0, bubble_ex=1. Release -> next edge instr_id=32'h8C410004, valid_id=1.
- Load-use: valid_id=1, stall_req=1 for 1 cycle with instr_if=32'h00221820 -> that cycle pc_write_en=0, bubble_ex=1, instr_id unchanged. Next cycle stall_req=0 -> instr_id=32'h00221820.
- Flush beats stall: flush_req=1 and stall_req=1 together -> pc_write_en=1, bubble_ex=0. Next edge instr_id=NOP, valid_id=0.
- Bubble gating: valid_id=0, stall_req=1 -> pc_write_en=1, no hold.
- Watchdog: MAX_STALL=2, stall_req held high 5 cycles with valid_id=1 -> pc_write_en pattern 0,0,1,0,0; stall_overflow=1 from the 3rd edge and stays set.
- Perf (IF_ID_STALL_PERF_EN defined): 3 single-cycle load-use stalls separated by advances -> stall_cycles=3. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the NOP encoding, opcode field constants and the
// hazard controller state encoding.
package pipeline_pkg;

    localparam logic [5:0]  OPC_RTYPE      = 6'b000000;
    localparam logic [5:0]  OPC_STORE_MASK = 6'b101000;
    localparam logic [5:0]  OPC_JUMP_MASK  = 6'b000010;
    localparam logic [31:0] NOP_INSTR      = {OPC_RTYPE, 26'd0};
    localparam int          CNT_W          = 4;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog: counts held cycles, converts the stall into a
// forced advance once MAX_STALL is reached and latches a sticky overflow flag.
module stall_watchdog
    import pipeline_pkg::*;
#(
    parameter int MAX_STALL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic eff_stall,
    input  logic flush_req,
    output logic hold,
    output logic stall_overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    hz_state_t        state;
    hz_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             release_wd;

    always_comb begin
        hold       = 1'b0;
        release_wd = 1'b0;
        state_nxt  = RUN;
        cnt_nxt    = '0;
        if (!flush_req && eff_stall) begin
            if (cnt < MAX_CNT) begin
                hold      = 1'b1;
                state_nxt = STALL;
                // a fresh stall out of RUN always starts counting at one
                cnt_nxt   = (state == RUN) ? CNT_W'(1) : cnt + CNT_W'(1);
            end else begin
                release_wd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            cnt            <= '0;
            stall_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (release_wd)
                stall_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use stall, flush and stall watchdog.
// Optional held-cycle counter built only when IF_ID_STALL_PERF_EN is defined.
module if_id_hazard_reg
    import pipeline_pkg::*;
#(
    parameter int          MAX_STALL = 1,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        flush_req,
    input  logic [31:0] instr_if,
    input  logic [31:0] pc_plus4_if,
    output logic [31:0] instr_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id,
    output logic        pc_write_en,
    output logic        bubble_ex,
    output logic        stall_overflow,
    output logic [31:0] stall_cycles
);

    generate
        if (MAX_STALL < 1 || MAX_STALL > 15) begin : g_bad_max_stall
            $error("if_id_hazard_reg: MAX_STALL must be in 1..15");
        end
    endgenerate

    logic eff_stall;
    logic hold;

    // a bubble sitting in ID has no dependency to protect, so it never stalls
    assign eff_stall = stall_req & valid_id;

    stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk            (clk),
        .reset          (reset),
        .eff_stall      (eff_stall),
        .flush_req      (flush_req),
        .hold           (hold),
        .stall_overflow (stall_overflow)
    );

    assign pc_write_en = !reset && !hold;
    assign bubble_ex   = reset || hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= '0;
            valid_id    <= 1'b0;
        end else if (flush_req) begin
            instr_id    <= NOP_INSTR;
            pc_plus4_id <= pc_plus4_if;
            valid_id    <= 1'b0;
        end else if (!hold) begin
            instr_id    <= instr_if;
            pc_plus4_id <= pc_plus4_if;
            valid_id    <= 1'b1;
        end
    end

`ifdef IF_ID_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (!pc_write_en && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
